// File: rtl/dfh_walker.sv
// dfh_walker: walks a Device Feature Header linked list over an AXI4-lite
// read channel. Each DFH is recorded in a small table of
// {type, ver, id, 8'h0, addr20}. The walk stops on EOL or on a zero next
// offset, and aborts with an error code on a bad response, a timeout, a
// misaligned offset, an address wrap or a full table.
`timescale 1ns/1ps
module dfh_walker #(
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_FEAT       = 16,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [2:0]                      err_code,
  output logic [$clog2(MAX_FEAT+1)-1:0]   feat_count,
  input  logic [$clog2(MAX_FEAT)-1:0]     tbl_idx,
  output logic [47:0]                     tbl_entry,
  output logic [ADDR_WIDTH-1:0]           araddr,
  output logic                            arvalid,
  output logic [2:0]                      arprot,
  input  logic                            arready,
  input  logic [DATA_WIDTH-1:0]           rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rvalid,
  output logic                            rready,
  output logic                            awvalid,
  output logic                            wvalid,
  output logic                            bready
);

  localparam int FC_W  = $clog2(MAX_FEAT + 1);
  localparam int IDX_W = $clog2(MAX_FEAT);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int OFF_W = 24;
  // One extra bit above the wider of address and offset holds the carry.
  localparam int SUM_W = ((ADDR_WIDTH > OFF_W) ? ADDR_WIDTH : OFF_W) + 1;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_RESP  = 3'd1;
  localparam logic [2:0] E_TMO   = 3'd2;
  localparam logic [2:0] E_OVF   = 3'd3;
  localparam logic [2:0] E_ALIGN = 3'd4;
  localparam logic [2:0] E_WRAP  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_EVAL, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [FC_W-1:0]         feat_count_q, feat_count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [2:0]              err_code_q, err_code_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    rready_q, rready_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [47:0]             tbl_entry_q, tbl_entry_d;

  // Captured DFH fields (datapath, not reset)
  logic [3:0]              dfh_type_q, dfh_type_d;
  logic [3:0]              dfh_ver_q, dfh_ver_d;
  logic [11:0]             dfh_id_q, dfh_id_d;
  logic                    dfh_eol_q, dfh_eol_d;
  logic [OFF_W-1:0]        dfh_next_q, dfh_next_d;
  logic                    resp_err_q, resp_err_d;

  logic [47:0]             tbl_mem [MAX_FEAT];
  logic                    tbl_we;
  logic [IDX_W-1:0]        tbl_widx;
  logic [47:0]             tbl_wdata;

  logic [SUM_W-1:0]        next_sum;
  logic                    next_wrap;
  logic [FC_W-1:0]         fc_inc;

  // DFH bits the walker does not interpret.
  logic                    unused_rd;
  assign unused_rd = ^{rdata[59:41], rresp[0]};

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign feat_count = feat_count_q;
  assign tbl_entry  = tbl_entry_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign arprot     = 3'b000;
  assign awvalid    = 1'b0;
  assign wvalid     = 1'b0;
  assign bready     = 1'b1;

  // Walk sequencing: next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    feat_count_d = feat_count_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    tmo_d        = tmo_q;
    tbl_entry_d  = tbl_mem[tbl_idx];
    dfh_type_d   = dfh_type_q;
    dfh_ver_d    = dfh_ver_q;
    dfh_id_d     = dfh_id_q;
    dfh_eol_d    = dfh_eol_q;
    dfh_next_d   = dfh_next_q;
    resp_err_d   = resp_err_q;
    tbl_we       = 1'b0;
    tbl_widx     = IDX_W'(feat_count_q);
    tbl_wdata    = {dfh_type_q, dfh_ver_q, dfh_id_q, 8'h00, 20'(cur_addr_q)};
    next_sum     = SUM_W'(cur_addr_q) + SUM_W'(dfh_next_q);
    next_wrap    = |next_sum[SUM_W-1:ADDR_WIDTH];
    fc_inc       = feat_count_q + FC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_AR;
          cur_addr_d   = BASE_ADDR;
          feat_count_d = '0;
          done_d       = 1'b0;
          err_d        = 1'b0;
          err_code_d   = E_NONE;
          busy_d       = 1'b1;
          arvalid_d    = 1'b1;
          araddr_d     = BASE_ADDR;
          tmo_d        = '0;
        end
      end
      S_AR: begin
        if (arvalid_q && arready) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = tmo_q + TMO_W'(1);
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_FIN;
          arvalid_d  = 1'b0;
          err_code_d = E_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_R: begin
        if (rvalid && rready_q) begin
          state_d    = S_EVAL;
          rready_d   = 1'b0;
          dfh_type_d = rdata[63:60];
          dfh_ver_d  = rdata[15:12];
          dfh_id_d   = rdata[11:0];
          dfh_eol_d  = rdata[40];
          dfh_next_d = rdata[39:16];
          resp_err_d = rresp[1];
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_FIN;
          rready_d   = 1'b0;
          err_code_d = E_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_EVAL: begin
        state_d = S_FIN;
        if (resp_err_q) begin
          err_code_d = E_RESP;
        end else begin
          tbl_we       = 1'b1;
          feat_count_d = fc_inc;
          if (dfh_eol_q || (dfh_next_q == '0)) begin
            err_code_d = E_NONE;
          end else if (dfh_next_q[2:0] != 3'b000) begin
            err_code_d = E_ALIGN;
          end else if (next_wrap) begin
            err_code_d = E_WRAP;
          end else if (fc_inc == FC_W'(MAX_FEAT)) begin
            err_code_d = E_OVF;
          end else begin
            state_d    = S_AR;
            cur_addr_d = next_sum[ADDR_WIDTH-1:0];
            araddr_d   = next_sum[ADDR_WIDTH-1:0];
            arvalid_d  = 1'b1;
            tmo_d      = '0;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (err_code_q == E_NONE) done_d = 1'b1;
        else                      err_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous active-low reset on control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      feat_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= E_NONE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      tmo_q        <= '0;
      tbl_entry_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      feat_count_q <= feat_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      tmo_q        <= tmo_d;
      tbl_entry_q  <= tbl_entry_d;
    end
    dfh_type_q <= dfh_type_d;
    dfh_ver_q  <= dfh_ver_d;
    dfh_id_q   <= dfh_id_d;
    dfh_eol_q  <= dfh_eol_d;
    dfh_next_q <= dfh_next_d;
    resp_err_q <= resp_err_d;
  end

  // Feature table storage; a same-cycle read sees the previous contents.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_mem[tbl_widx] <= tbl_wdata;
  end

endmodule

// File: tb/tb_dfh_walker.sv
// Bench for dfh_walker: an AXI-lite read slave backed by a sparse DFH
// memory, a list-walking reference model feeding scoreboard queues, and a
// monitor that checks every AR handshake and every finished walk.
`timescale 1ns/1ps
module tb_dfh_walker;

  localparam int AW   = 20;
  localparam int MAXF = 4;
  localparam int TMO  = 16;

  typedef struct packed {
    logic                  done;
    logic                  err;
    logic [2:0]            code;
    logic [7:0]            cnt;
    logic [MAXF-1:0][47:0] tbl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, err;
  logic [2:0]    err_code;
  logic [2:0]    feat_count;
  logic [1:0]    tbl_idx;
  logic [47:0]   tbl_entry;
  logic [AW-1:0] araddr;
  logic          arvalid, arready, rvalid, rready;
  logic [2:0]    arprot;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic          awvalid, wvalid, bready;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0]  dfh_mem [int unsigned];
  bit           rerr    [int unsigned];
  bit           mute    [int unsigned];
  exp_t         exp_q [$];
  int unsigned  ar_q  [$];
  bit           mon_busy = 1'b0;
  bit           slv_flush = 1'b0;
  int           ar_lat = 0;

  dfh_walker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(64), .BASE_ADDR('0),
    .MAX_FEAT(MAXF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .feat_count(feat_count),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry), .araddr(araddr),
    .arvalid(arvalid), .arprot(arprot), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .awvalid(awvalid),
    .wvalid(wvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [63:0] rd_mem(input int unsigned a);
    return dfh_mem.exists(a) ? dfh_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] ty, input logic [3:0] ver,
                                     input logic [11:0] id, input logic eol,
                                     input logic [23:0] off);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[63:60] = ty; d[40] = eol; d[39:16] = off; d[15:12] = ver; d[11:0] = id;
    return d;
  endfunction

  // Reference: follow the list from base with plain arithmetic.
  task automatic predict(input bit push_res);
    exp_t        e;
    int unsigned addr, off;
    logic [63:0] d;
    e = '0;
    addr = 0;
    for (int g = 0; g < 64; g++) begin
      ar_q.push_back(addr);
      if (mute.exists(addr)) begin e.code = 3'd2; break; end
      d = rd_mem(addr);
      if (rerr.exists(addr)) begin e.code = 3'd1; break; end
      e.tbl[e.cnt] = {d[63:60], d[15:12], d[11:0], 8'h00, addr[19:0]};
      e.cnt = e.cnt + 8'd1;
      off = {8'h0, d[39:16]};
      if (d[40] || off == 0) break;
      if (off % 8 != 0) begin e.code = 3'd4; break; end
      if (addr + off > 32'hFFFFF) begin e.code = 3'd5; break; end
      if (e.cnt == MAXF) begin e.code = 3'd3; break; end
      addr = addr + off;
    end
    e.done = (e.code == 3'd0);
    e.err  = (e.code != 3'd0);
    if (push_res) exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    dfh_mem.delete(); rerr.delete(); mute.delete();
  endtask

  task automatic build_random();
    int unsigned addr, off;
    int n, kind;
    logic [63:0] d;
    clear_mem();
    n = $urandom_range(1, 6);
    addr = 0;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 19);
      off  = 8 * $urandom_range(1, 4096);
      if (kind == 0) off = off | 4;
      if (kind == 1) off = 32'h100000 - addr + 8 * $urandom_range(0, 16);
      if (i == n - 1) begin
        if ($urandom_range(0, 1) == 1) d = mk(4'($urandom), 4'($urandom), 12'($urandom), 1'b1, 24'($urandom));
        else                           d = mk(4'($urandom), 4'($urandom), 12'($urandom), 1'b0, 24'h0);
      end else begin
        d = mk(4'($urandom), 4'($urandom), 12'($urandom), 1'b0, off[23:0]);
      end
      if (kind == 2) rerr[addr] = 1'b1;
      dfh_mem[addr] = d;
      if (addr + off > 32'hFFFFF) break;
      addr = addr + off;
    end
  endtask

  // AXI-lite read slave: drives on the falling edge.
  initial begin : slave
    bit seen_ar, seen_rr;
    int unsigned seen_addr, cur;
    int sst, ar_wait, r_wait;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    seen_ar = 0; seen_rr = 0; seen_addr = 0; cur = 0;
    sst = 0; ar_wait = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || slv_flush) begin
        arready = 0; rvalid = 0; sst = 0; ar_wait = 0;
        seen_ar = 0; seen_rr = 0; slv_flush = 0;
      end else begin
        if (arready && seen_ar) begin
          sst = 1; cur = seen_addr; r_wait = $urandom_range(0, 4);
          ar_wait = 0; ar_lat = $urandom_range(0, 3);
        end
        if (rvalid && seen_rr) begin
          rvalid = 0; sst = 0;
        end
        arready = 0;
        if (sst == 0 && arvalid) begin
          if (ar_wait >= ar_lat) arready = 1;
          else ar_wait++;
        end else if (sst == 1 && !rvalid && !mute.exists(cur)) begin
          if (r_wait > 0) r_wait--;
          else begin
            rvalid = 1;
            rdata  = rd_mem(cur);
            rresp  = rerr.exists(cur) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
          end
        end
        seen_ar = arvalid; seen_rr = rready; seen_addr = {12'h0, araddr};
      end
    end
  end

  // Monitor: samples between edges, checks AR addresses and walk results.
  initial begin : monitor
    exp_t e;
    bit prev_fin;
    int unsigned a;
    prev_fin = 0;
    tbl_idx = '0;
    forever begin
      @(negedge clk); #2;
      if (rst_n && arvalid && arready) begin
        if (ar_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL ar_unexpected: got addr %0h, none expected", araddr);
        end else begin
          a = ar_q.pop_front();
          chk("ar_addr", {44'h0, araddr}, {32'h0, a});
        end
      end
      if (rst_n && (done || err) && !prev_fin) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL result_unexpected: got done=%0b err=%0b, none expected", done, err);
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1;
          chk("done", done, e.done);
          chk("err", err, e.err);
          chk("err_code", err_code, e.code);
          chk("feat_count", feat_count, e.cnt);
          chk("busy_at_end", busy, 0);
          chk("ar_outstanding", ar_q.size(), 0);
          for (int i = 0; i < 32'(e.cnt); i++) begin
            tbl_idx = 2'(i);
            @(negedge clk); #2;
            chk($sformatf("tbl_entry[%0d]", i), tbl_entry, e.tbl[i]);
          end
          mon_busy = 0;
        end
      end
      prev_fin = rst_n && (done || err);
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("busy_after_start", busy, 1);
    chk("flags_cleared", {done, err, err_code}, 0);
    chk("fc_cleared", feat_count, 0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((done || err) && !mon_busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL walk_timeout: got busy=%0b done=%0b err=%0b, required walk completion", busy, done, err);
    end
  endtask

  // Stimulus
  initial begin : stim
    bit ok;
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, err, arvalid, rready}, 0);
    chk("rst_code", {err_code, feat_count}, 0);
    chk("rst_addr", araddr, 0);
    chk("rst_tbl", tbl_entry, 0);
    chk("tie_offs", {arprot, awvalid, wvalid, bready}, 6'b000_001);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Three-entry chain ending on EOL.
    clear_mem();
    dfh_mem[32'h0]    = mk(4'h1, 4'h1, 12'h001, 1'b0, 24'h001000);
    dfh_mem[32'h1000] = mk(4'h2, 4'h0, 12'h010, 1'b0, 24'h002000);
    dfh_mem[32'h3000] = mk(4'h3, 4'h2, 12'h0AB, 1'b1, 24'h00F00D);
    predict(1); do_start(); wait_done();

    // Single DFH, zero offset, arready held low for five cycles.
    clear_mem();
    dfh_mem[32'h0] = mk(4'h5, 4'h1, 12'h123, 1'b0, 24'h0);
    ar_lat = 5;
    predict(1); do_start();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, 0);
    end
    wait_done();

    // Bad response on the second read, then a clean restart.
    clear_mem();
    dfh_mem[32'h0]    = mk(4'h1, 4'h0, 12'h002, 1'b0, 24'h001000);
    dfh_mem[32'h1000] = mk(4'h1, 4'h0, 12'h003, 1'b1, 24'h0);
    rerr[32'h1000] = 1'b1;
    predict(1); do_start(); wait_done();
    rerr.delete();
    predict(1); do_start(); wait_done();

    // Timeout on the second read.
    clear_mem();
    dfh_mem[32'h0] = mk(4'h4, 4'h0, 12'h004, 1'b0, 24'h001000);
    mute[32'h1000] = 1'b1;
    predict(1); do_start();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arvalid && araddr == 20'h01000) begin ok = 1; break; end
    end
    chk("tmo_second_ar_seen", ok, 1);
    repeat (15) @(negedge clk);
    chk("tmo_not_early", err_code, 0);
    @(negedge clk);
    chk("tmo_code_at_16", err_code, 2);
    chk("tmo_bus_idle", {arvalid, rready}, 0);
    @(negedge clk);
    chk("tmo_err_flag", {err, busy}, 2'b10);
    wait_done();
    slv_flush = 1; mute.delete();
    repeat (2) @(negedge clk);

    // Table overflow, misaligned offset, address wrap.
    clear_mem();
    for (int i = 0; i < 5; i++)
      dfh_mem[32'h100 * i] = mk(4'(i), 4'h1, 12'(i + 7), 1'b0, 24'h000100);
    predict(1); do_start(); wait_done();
    clear_mem();
    dfh_mem[32'h0] = mk(4'h6, 4'h2, 12'h0C0, 1'b0, 24'h001004);
    predict(1); do_start(); wait_done();
    clear_mem();
    dfh_mem[32'h0]     = mk(4'h7, 4'h3, 12'h0D0, 1'b0, 24'h0FF000);
    dfh_mem[32'hFF000] = mk(4'h8, 4'h4, 12'h0E0, 1'b0, 24'h002000);
    predict(1); do_start(); wait_done();

    // Reset while a read is in flight.
    clear_mem();
    dfh_mem[32'h0] = mk(4'h9, 4'h0, 12'h0F0, 1'b0, 24'h001000);
    mute[32'h1000] = 1'b1;
    predict(0); do_start();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rready && feat_count == 3'd1) begin ok = 1; break; end
    end
    chk("rst_mid_in_r", ok, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_mid_ctrl", {busy, arvalid, rready, done, err}, 0);
    chk("rst_mid_fc", feat_count, 0);
    slv_flush = 1; mute.delete();
    repeat (3) @(negedge clk);
    chk("rst_mid_ar_seen", ar_q.size(), 0);

    // Randomised chains.
    for (int w = 0; w < 40; w++) begin
      build_random();
      predict(1); do_start(); wait_done();
    end

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("ar_q_empty", ar_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
